// File: rtl/iob_uart_tx_arb_if.sv
// Requester streams and UART core transmit-write port of the transmit arbiter.
// slave = arbiter side, master = requesters plus UART core side.
interface iob_uart_tx_arb_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_last;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ-1:0]   grant;
   logic               busy;
   logic               uart_tx_ready;
   logic               uart_wr;
   logic [7:0]         uart_tx_data;

   modport slave (
      input  req_valid, req_data, req_last, uart_tx_ready,
      output req_ready, grant, busy, uart_wr, uart_tx_data
   );

   modport master (
      output req_valid, req_data, req_last, uart_tx_ready,
      input  req_ready, grant, busy, uart_wr, uart_tx_data
   );
endinterface

// File: rtl/iob_uart_tx_arb.sv
// Packet-locked round-robin arbiter feeding the UART transmit-data port.
// Grant 1 cycle after request, write 1 cycle after accept; accepts gated by uart_tx_ready and tx_en.
module iob_uart_tx_arb #(
   parameter int N_REQ     = 4,
   parameter int TIMEOUT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               soft_rst,
   input  logic               tx_en,
   iob_uart_tx_arb_if.slave   io
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   // Release fires on the edge where the idle count would become all-ones.
   localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {IDLE, LOCK, HOLD, REL} state_t;

   state_t               state;
   logic [PW-1:0]        ptr;
   logic [PW-1:0]        own;
   logic [PW-1:0]        nxt_own;
   logic [PW-1:0]        win;
   logic [PW-1:0]        cand;
   logic                 found;
   logic                 own_vld;
   logic                 accept;
   logic                 hcnt;
   logic [TIMEOUT_W-1:0] tmo;

   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = PW'((int'(ptr) + k) % N_REQ);
         if (!found && io.req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign own_vld      = io.req_valid[own];
   assign nxt_own      = (own == PW'(N_REQ - 1)) ? '0 : own + 1'b1;
   // soft_rst masks the handshake so a byte is never taken and then dropped.
   assign accept       = (state == LOCK) && tx_en && io.uart_tx_ready && own_vld && !soft_rst;
   assign io.req_ready = accept ? io.grant : '0;
   assign io.busy      = (|io.grant) || (state == HOLD);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         ptr             <= '0;
         own             <= '0;
         hcnt            <= 1'b0;
         tmo             <= '0;
         io.grant        <= '0;
         io.uart_wr      <= 1'b0;
         io.uart_tx_data <= '0;
      end else if (soft_rst) begin
         state           <= IDLE;
         ptr             <= '0;
         own             <= '0;
         hcnt            <= 1'b0;
         tmo             <= '0;
         io.grant        <= '0;
         io.uart_wr      <= 1'b0;
         io.uart_tx_data <= '0;
      end else begin
         io.uart_wr <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_en && found) begin
                  own      <= win;
                  io.grant <= N_REQ'(1) << win;
                  tmo      <= '0;
                  state    <= LOCK;
               end
            end
            LOCK: begin
               if (accept) begin
                  io.uart_wr      <= 1'b1;
                  io.uart_tx_data <= io.req_data[8*own +: 8];
                  tmo             <= '0;
                  hcnt            <= 1'b0;
                  if (io.req_last[own]) begin
                     ptr      <= nxt_own;
                     io.grant <= '0;
                     state    <= REL;
                  end else begin
                     state <= HOLD;
                  end
               end else if (own_vld) begin
                  tmo <= '0;
               end else if (tmo == TMO_LAST) begin
                  ptr      <= nxt_own;
                  io.grant <= '0;
                  tmo      <= '0;
                  state    <= IDLE;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            HOLD: begin
               hcnt <= ~hcnt;
               if (hcnt) state <= LOCK;
            end
            REL: begin
               hcnt <= ~hcnt;
               if (hcnt) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_iob_uart_tx_arb.sv
// Directed bench for iob_uart_tx_arb: reset, packets, fairness, backpressure, timeout, soft reset.
module tb_iob_uart_tx_arb;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic soft_rst;
   logic tx_en;

   iob_uart_tx_arb_if #(.N_REQ(N)) bus();

   iob_uart_tx_arb #(.N_REQ(N), .TIMEOUT_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .soft_rst (soft_rst),
      .tx_en    (tx_en),
      .io       (bus)
   );

   always #5 clk = ~clk;

   int         n_chk = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         btb = 0;
   int         bad_rdy = 0;
   logic       prev_wr = 1'b0;
   logic [N-1:0] prev_gnt = '0;
   logic [7:0] wr_q[$];
   int         wr_cyc[$];
   logic [N-1:0] gnt_q[$];
   int         gnt_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Passive observers: write log, grant log, back-to-back strobes, ready to a non-owner.
   always @(negedge clk) begin
      if (bus.uart_wr) begin
         wr_q.push_back(bus.uart_tx_data);
         wr_cyc.push_back(cyc);
         if (prev_wr) btb++;
      end
      prev_wr = bus.uart_wr;
      if (bus.grant != '0 && bus.grant != prev_gnt) begin
         gnt_q.push_back(bus.grant);
         gnt_cyc.push_back(cyc);
      end
      prev_gnt = bus.grant;
      if ((bus.req_ready & ~bus.grant) != '0) bad_rdy++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_byte(input int i, input logic [7:0] b);
      bus.req_data[8*i +: 8] = b;
   endtask

   initial begin
      logic [7:0]   exp_wr[5];
      logic [N-1:0] exp_gnt[5];
      int ok;
      int acc;
      int cnt_r;
      int cnt_w;
      int gnt_seen;

      soft_rst = 1'b0;
      tx_en = 1'b0;
      bus.req_valid = '0;
      bus.req_data = '0;
      bus.req_last = '0;
      bus.uart_tx_ready = 1'b0;

      // Reset held with random stimulus
      repeat (5) begin
         step();
         tx_en             = 1'($urandom);
         soft_rst          = 1'($urandom);
         bus.req_valid     = N'($urandom);
         bus.req_data      = (8*N)'($urandom);
         bus.req_last      = N'($urandom);
         bus.uart_tx_ready = 1'($urandom);
      end
      @(negedge clk);
      chk("rst_wr", bus.uart_wr, 0);
      chk("rst_data", bus.uart_tx_data, 0);
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_grant", bus.grant, 0);
      chk("rst_busy", bus.busy, 0);

      step();
      tx_en = 1'b0; soft_rst = 1'b0;
      bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.uart_tx_ready = 1'b0;
      rst = 1'b1;
      step();

      // First grant, one cycle after request
      tx_en = 1'b1;
      bus.req_valid = 4'b0001;
      set_byte(0, 8'h11);
      bus.req_last = 4'b0001;
      @(negedge clk);
      chk("first_pre", bus.grant, 0);
      step();
      @(negedge clk);
      chk("first_grant", bus.grant, 4'b0001);
      chk("first_busy", bus.busy, 1);
      chk("first_noacc", bus.req_ready, 0);
      step();
      bus.uart_tx_ready = 1'b1;
      @(negedge clk);
      chk("first_acc", bus.req_ready, 4'b0001);
      step();
      bus.req_valid = '0;
      @(negedge clk);
      chk("first_wr", bus.uart_wr, 1);
      chk("first_wdat", bus.uart_tx_data, 8'h11);
      repeat (3) step();

      // Two-byte packet from requester 2 (ptr is now 1)
      wr_q.delete(); wr_cyc.delete();
      bus.req_valid = 4'b0100;
      set_byte(2, 8'hA5);
      bus.req_last = 4'b0000;
      step();
      @(negedge clk);
      chk("sp_grant", bus.grant, 4'b0100);
      chk("sp_acc1", bus.req_ready, 4'b0100);
      step();
      set_byte(2, 8'h5A);
      bus.req_last = 4'b0100;
      ok = 0;
      for (int i = 0; i < 10 && ok == 0; i++) begin
         @(negedge clk);
         if (bus.req_ready[2]) ok = 1;
         else step();
      end
      chk("sp_acc2_seen", ok, 1);
      step();
      bus.req_valid = '0;
      step(); step();
      @(negedge clk);
      chk("sp_release", bus.grant, 0);
      chk("sp_nwr", wr_q.size(), 2);
      if (wr_q.size() == 2) begin
         chk("sp_byte0", wr_q[0], 8'hA5);
         chk("sp_byte1", wr_q[1], 8'h5A);
         chk("sp_spacing", wr_cyc[1] - wr_cyc[0], 3);
      end
      step();

      // Fairness: all requesters stream one-byte packets, ptr starts at 3
      wr_q.delete(); wr_cyc.delete(); gnt_q.delete(); gnt_cyc.delete();
      for (int i = 0; i < N; i++) set_byte(i, 8'hC0 + 8'(i));
      bus.req_last = 4'b1111;
      bus.req_valid = 4'b1111;
      acc = 0;
      for (int i = 0; i < 60 && acc < 5; i++) begin
         @(negedge clk);
         if (bus.req_ready != '0) acc++;
         step();
      end
      bus.req_valid = '0;
      chk("rr_accepts", acc, 5);
      repeat (4) step();
      exp_gnt = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      exp_wr  = '{8'hC3, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
      chk("rr_ngrant", gnt_q.size(), 5);
      chk("rr_nwr", wr_q.size(), 5);
      for (int i = 0; i < 5 && i < gnt_q.size(); i++) begin
         chk($sformatf("rr_grant%0d", i), gnt_q[i], exp_gnt[i]);
         if (i > 0) chk($sformatf("rr_gap%0d", i), gnt_cyc[i] - gnt_cyc[i-1], 4);
      end
      for (int i = 0; i < 5 && i < wr_q.size(); i++)
         chk($sformatf("rr_byte%0d", i), wr_q[i], exp_wr[i]);

      // Backpressure mid-packet, requester 1 (ptr is now 0)
      bus.req_valid = 4'b0010;
      set_byte(1, 8'h31);
      bus.req_last = 4'b0000;
      bus.uart_tx_ready = 1'b1;
      step();
      @(negedge clk);
      chk("bp_acc1", bus.req_ready, 4'b0010);
      step();
      set_byte(1, 8'h32);
      bus.req_last = 4'b0010;
      bus.uart_tx_ready = 1'b0;
      cnt_r = 0; cnt_w = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.req_ready != '0) cnt_r++;
         if (i > 0 && bus.uart_wr) cnt_w++;
         step();
      end
      chk("bp_no_ready", cnt_r, 0);
      chk("bp_no_wr", cnt_w, 0);
      bus.uart_tx_ready = 1'b1;
      @(negedge clk);
      chk("bp_lock_kept", bus.grant, 4'b0010);
      chk("bp_resume_acc", bus.req_ready, 4'b0010);
      chk("bp_resume_nowr", bus.uart_wr, 0);
      step();
      bus.req_valid = '0;
      @(negedge clk);
      chk("bp_resume_wr", bus.uart_wr, 1);
      chk("bp_resume_dat", bus.uart_tx_data, 8'h32);
      repeat (3) step();

      // Idle timeout (ptr is now 2): owner 2 goes quiet, requester 3 waits
      wr_q.delete(); wr_cyc.delete();
      set_byte(2, 8'h41);
      set_byte(3, 8'h51);
      bus.req_last = 4'b1000;
      bus.req_valid = 4'b1100;
      step();
      @(negedge clk);
      chk("to_grant", bus.grant, 4'b0100);
      chk("to_acc", bus.req_ready, 4'b0100);
      step();
      bus.req_valid = 4'b1000;
      repeat (16) step();
      @(negedge clk);
      chk("to_still_owned", bus.grant, 4'b0100);
      step();
      @(negedge clk);
      chk("to_released", bus.grant, 0);
      step();
      @(negedge clk);
      chk("to_next_grant", bus.grant, 4'b1000);
      chk("to_next_acc", bus.req_ready, 4'b1000);
      step();
      bus.req_valid = '0;
      repeat (3) step();
      chk("to_nwr", wr_q.size(), 2);
      if (wr_q.size() == 2) chk("to_byte1", wr_q[1], 8'h51);

      // tx_en low blocks arbitration (ptr is now 0)
      tx_en = 1'b0;
      bus.req_valid = 4'b0010;
      set_byte(1, 8'h71);
      bus.req_last = 4'b0010;
      gnt_seen = 0;
      repeat (3) begin
         step();
         @(negedge clk);
         if (bus.grant != '0) gnt_seen++;
      end
      chk("en_no_grant", gnt_seen, 0);
      step();
      tx_en = 1'b1;
      step();
      @(negedge clk);
      chk("en_grant", bus.grant, 4'b0010);
      step();
      bus.req_valid = '0;
      repeat (3) step();

      // Soft reset in HOLD (ptr is now 2), re-arbitration from ptr 0
      set_byte(0, 8'h60);
      set_byte(2, 8'h61);
      bus.req_last = 4'b0000;
      bus.req_valid = 4'b0101;
      step();
      @(negedge clk);
      chk("sr_grant", bus.grant, 4'b0100);
      step();
      soft_rst = 1'b1;
      @(negedge clk);
      chk("sr_hold_wr", bus.uart_wr, 1);
      chk("sr_hold_busy", bus.busy, 1);
      step();
      soft_rst = 1'b0;
      @(negedge clk);
      chk("sr_wr", bus.uart_wr, 0);
      chk("sr_data", bus.uart_tx_data, 0);
      chk("sr_grant0", bus.grant, 0);
      chk("sr_busy", bus.busy, 0);
      chk("sr_ready", bus.req_ready, 0);
      step();
      @(negedge clk);
      chk("sr_rearb", bus.grant, 4'b0001);
      step();
      bus.req_valid = '0;
      repeat (2) step();

      chk("wr_back_to_back", btb, 0);
      chk("ready_non_owner", bad_rdy, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
